ram_burst_read_port: RTL
========================

Name: ram_burst_read_port

Overview:
- Parametrised successor to the single-bit, 256-entry RAM output selector.
- Selects a WIDTH-bit word from the flattened RAM cell-output bus at a registered memory-address (MAR) value.
- Adds a MAR register, burst reads with auto-increment and wrap-around, and a registered valid/ready output stage.
- Sits between the RAM cell array and the processor data bus; the control unit issues read requests.

Parameters:
- DEPTH, 256: number of RAM words; power of two, >= 2.
- WIDTH, 8: bits per word.
- AW, $clog2(DEPTH): address width; derived, not overridden.
- BLW, 4: width of the burst-length field.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RAM_cell_op  input  DEPTH*WIDTH  flattened cell outputs; word k = bits [k*WIDTH +: WIDTH].
- MAR_BUS  input  AW  address to load into the MAR.
- mar_load  input  1  load MAR_BUS into the MAR (IDLE only).
- rd_req  input  1  start a burst read (IDLE only).
- burst_len  input  BLW  words in the burst; 0 is treated as 1.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_data  output  WIDTH  registered read word.
- rd_valid  output  1  rd_data holds an unconsumed word.
- busy  output  1  high in READ and DRAIN.
- burst_done  output  1  one-cycle pulse when the last word of a burst is accepted.
- mar_q  output  AW  current MAR value.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE; mar_q=0; count=0.
  - rd_data=0; rd_valid=0; busy=0; burst_done=0.
  - Reset mid-burst aborts immediately; no partial state survives.
- Word select: sel = RAM_cell_op[mar_q*WIDTH +: WIDTH], purely combinational, sampled at the capture edge.
- Output slot: one entry.
  - free = !rd_valid || rd_ready.
  - Capture only when free.
  - Without a capture, rd_ready clears rd_valid; rd_data is held.
- IDLE:
  - mar_load: mar_q <= MAR_BUS.
  - rd_req: count <= (burst_len==0 ? 1 : burst_len); if mar_load is also high, the burst starts at MAR_BUS (load takes priority); go to READ.
  - rd_req without mar_load: burst starts at the current mar_q.
- READ:
  - Each edge with free: rd_data <= sel; rd_valid <= 1; mar_q <= (mar_q+1) mod DEPTH; count <= count-1.
  - When count goes 1 -> 0 on a capture: go to DRAIN.
  - No free slot: stall; mar_q, count and rd_data hold.
- DRAIN:
  - Wait for the final word to be accepted (rd_valid && rd_ready).
  - Then burst_done=1 for one cycle and go to IDLE.
- Latency: rd_req sampled at edge N, first word valid after edge N+1.
  - With rd_ready held high: one word per cycle.
  - L-word burst: last word valid after edge N+L; burst_done high after edge N+L+1.
- Ignored inputs: mar_load and rd_req in READ or DRAIN have no effect (not queued).
- Wrap-around: address DEPTH-1 is followed by 0; a burst may cross the wrap.
- After a burst, mar_q points one past the last word read, so a back-to-back rd_req continues sequentially.
- RAM_cell_op changing mid-burst: each word reflects the array contents at its own capture edge.
- busy = (state != IDLE), registered-state decode.

Test Plan:
- Reset/load: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Release, mar_load with MAR_BUS=0x12 -> mar_q=0x12 next edge, rd_valid stays 0.
- Single read: word k = k XOR 0xA5, mar_q=0x12, rd_req with burst_len=0, rd_ready=1 -> rd_data=0xB7 valid one cycle, then burst_done pulse, mar_q=0x13, busy low.
- Burst with wrap: MAR_BUS=0xFE, mar_load and rd_req in the same cycle, burst_len=4 -> rd_data sequence 0x5B, 0x5A, 0xA5, 0xA4 on consecutive cycles, final mar_q=0x02.
- Backpressure: burst_len=3 from 0x10, rd_ready low for 3 cycles after the first word -> rd_data holds 0xB5, mar_q holds 0x11; on release the remaining words 0xB4, 0xB7 follow, with no loss or duplication.
- Ignored commands: mar_load=1 with MAR_BUS=0x40 and rd_req pulses during a 4-word burst -> burst completes unchanged, mar_q ends at start+4, no second burst starts.
- Reset mid-burst: rst_n low on the 2nd word of an 8-word burst -> state IDLE, rd_valid=0, mar_q=0, no burst_done pulse. A fresh burst after release behaves normally.

Source files
------------

// File: rtl/ram_burst_read_port.sv
// ram_burst_read_port
// Read port between the RAM cell array and the processor data bus. Holds the
// memory address register (MAR), runs auto-incrementing burst reads that wrap
// at DEPTH, and presents each word through a one-entry valid/ready output slot.
module ram_burst_read_port #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 8,
  parameter  int BLW   = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] RAM_cell_op,
  input  logic [AW-1:0]          MAR_BUS,
  input  logic                   mar_load,
  input  logic                   rd_req,
  input  logic [BLW-1:0]         burst_len,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   burst_done,
  output logic [AW-1:0]          mar_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [BLW-1:0]   count;
  logic [WIDTH-1:0] sel;
  logic             free;

  // Word currently addressed by the MAR; sampled by the capture edge, so a
  // changing array is seen as it stands at each word's own capture.
  assign sel  = RAM_cell_op[mar_q*WIDTH +: WIDTH];

  // The output slot may take a new word when it is empty or being drained now.
  assign free = !rd_valid || rd_ready;

  // Decoded from the state register, so it never glitches on input changes.
  assign busy = (state != IDLE);

  // Burst controller, MAR and output slot in one registered process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mar_q      <= '0;
      count      <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the later capture assignment in READ
      // deliberately overrides the default slot clear below in the same edge.
      burst_done <= 1'b0;
      if (rd_ready) begin
        rd_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (mar_load) begin
            mar_q <= MAR_BUS;
          end
          if (rd_req) begin
            count <= (burst_len == '0) ? BLW'(1) : burst_len;
            state <= READ;
          end
        end

        READ: begin
          // Without a free slot everything holds: a stall, not a skip.
          if (free) begin
            rd_data  <= sel;
            rd_valid <= 1'b1;
            mar_q    <= mar_q + AW'(1);
            count    <= count - BLW'(1);
            if (count == BLW'(1)) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Burst is complete only once the consumer takes the last word.
          if (rd_valid && rd_ready) begin
            burst_done <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
